ushift_reg_burst: RTL and testbench
===================================

Name: ushift_reg_burst

Overview:
- Parametrised universal shift register, WIDTH bits wide.
- Supports hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Adds a burst engine: one start request shifts or rotates the register a programmed number of times, then pulses done.
- Used as the general-purpose serialiser/deserialiser and bit-manipulation register in datapaths that previously used the fixed 4-bit register.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 or more.
- COUNT_W, 4, width of the burst count input; maximum burst is 2^COUNT_W-1 operations.

Ports:
- Clck  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  in IDLE, applies mode to Q this cycle; ignored outside IDLE.
- mode  input  3  operation select; encoding under Behaviour.
- Sir  input  1  serial input entering at bit WIDTH-1 on shift right.
- Sil  input  1  serial input entering at bit 0 on shift left.
- Pin  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled only in IDLE.
- count  input  COUNT_W  number of burst operations, latched with start.
- Q  output  WIDTH  register contents.
- Sor  output  1  Q[0], combinational.
- Sol  output  1  Q[WIDTH-1], combinational.
- busy  output  1  high while in BURST.
- done  output  1  one-cycle pulse when a start request completes.

Behaviour:
- Mode encoding (N = Q before the edge):
  - 000 hold: Q unchanged.
  - 001 shr: Q <= {Sir, N[W-1:1]}.
  - 010 shl: Q <= {N[W-2:0], Sil}.
  - 011 load: Q <= Pin.
  - 100 rotr: Q <= {N[0], N[W-1:1]}.
  - 101 rotl: Q <= {N[W-2:0], N[W-1]}.
  - 110 ashr: Q <= {N[W-1], N[W-1:1]}.
  - 111 clear: Q <= 0.
- Reset while low: Q=0, busy=0, done=0, state=IDLE, internal count=0. This takes effect immediately, including mid-burst. Any burst in progress is lost and no done pulse is issued.
- States: IDLE, BURST, DONE.
- IDLE, start=0: if en=1, apply mode on this edge; if en=0, hold Q.
- IDLE, start=1 (takes priority over en):
  - Shift/rotate modes (001, 010, 100, 101, 110) with count>0: latch mode and count, apply the first operation on the same edge, set rem=count-1. Go to BURST if rem>0, otherwise go to DONE.
  - count=0 with any mode, or any non-shift mode (000, 011, 111): perform that mode once if it is a non-shift mode (count is ignored), leave Q unchanged if count=0 with a shift mode, then go to DONE.
- BURST: busy=1. Each cycle apply the latched mode and decrement rem. The edge that applies the final operation (rem was 1) moves to DONE.
  - mode, en, start, count and Pin are ignored in BURST.
  - Sir and Sil are sampled live on every burst cycle.
- DONE: done=1 and busy=0 for exactly one cycle, Q holds, then return to IDLE. start asserted in DONE is ignored.
- Total latency of a burst of N≥1 from the start edge: Q is final after N edges, and done is high during the cycle following the Nth edge.
- count ≥ WIDTH is legal. A burst of WIDTH rotates returns the original value.
- busy and done are registered outputs; Sor and Sol follow Q combinationally.

Optional Feature:
- Macro: USHIFT_REG_ABORT_EN.
- With the macro defined, an extra input port abort (1 bit) is present.
  - abort=1 in BURST: stop after the current edge without applying an operation on that edge, go to IDLE, and issue no done pulse. Q retains its partially shifted value.
  - abort is ignored in IDLE and DONE.
- Without the macro, the abort port is absent and bursts always run to completion.

Test Plan:
- Reset: drive reset low mid-burst (count=9, rotr) -> Q=0, busy=0 immediately; no done pulse follows release.
- Single ops, WIDTH=8, Q=8'hB4, en=1:
  - shr with Sir=1 -> 8'hDA
  - shl with Sil=1 -> 8'h69
  - rotr -> 8'h5A
  - rotl -> 8'h69
  - ashr -> 8'hDA
  - clear -> 8'h00
  - en=0 -> Q held at 8'hB4
- Burst rotate: Q=8'h81, start with mode=rotl, count=3 -> busy high for 2 cycles, Q=8'h0C after 3 edges, done high for one cycle, then IDLE.
- Burst serial-in: Q=8'h00, shr count=8, Sir driven 1,0,1,1,0,0,1,0 on successive edges -> Q=8'h4D, and mode changes during the burst have no effect.
- Degenerate starts:
  - start with count=0, mode=shl -> Q unchanged, done pulses on the next cycle.
  - start with mode=load, Pin=8'h3C -> Q=8'h3C, done pulses on the next cycle, busy never asserted.
- Abort (USHIFT_REG_ABORT_EN): Q=8'h01, rotl count=7, abort pulsed in the 3rd burst cycle -> Q=8'h04, IDLE, done never asserted.

Source files
------------

// File: rtl/ushift_reg_burst.sv
// Universal WIDTH-bit shift register with a counted shift/rotate burst engine.
// Optional abort input when USHIFT_REG_ABORT_EN is defined.
module ushift_reg_burst #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               Clck,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic               Sir,
  input  logic               Sil,
  input  logic [WIDTH-1:0]   Pin,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
`ifdef USHIFT_REG_ABORT_EN
  input  logic               abort,
`endif
  output logic [WIDTH-1:0]   Q,
  output logic               Sor,
  output logic               Sol,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [2:0]         mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] n,
    input logic             sir,
    input logic             sil,
    input logic [WIDTH-1:0] pin
  );
    case (m)
      3'b001:  apply_op = {sir, n[WIDTH-1:1]};
      3'b010:  apply_op = {n[WIDTH-2:0], sil};
      3'b011:  apply_op = pin;
      3'b100:  apply_op = {n[0], n[WIDTH-1:1]};
      3'b101:  apply_op = {n[WIDTH-2:0], n[WIDTH-1]};
      3'b110:  apply_op = {n[WIDTH-1], n[WIDTH-1:1]};
      3'b111:  apply_op = '0;
      default: apply_op = n;
    endcase
  endfunction

  function automatic logic is_shift(input logic [2:0] m);
    is_shift = (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
               (m == 3'b101) || (m == 3'b110);
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_shift(mode) && (count != '0)) begin
            // First operation lands on the start edge itself.
            q_d    = apply_op(mode, q_q, Sir, Sil, Pin);
            mode_d = mode;
            rem_d  = count - 1'b1;
            if (rem_d != '0) begin
              state_d = BURST;
              busy_d  = 1'b1;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            if (!is_shift(mode)) q_d = apply_op(mode, q_q, Sir, Sil, Pin);
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, Sir, Sil, Pin);
        end
      end
      BURST: begin
`ifdef USHIFT_REG_ABORT_EN
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
        end else
`endif
        begin
          q_d   = apply_op(mode_q, q_q, Sir, Sil, Pin);
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(COUNT_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clck or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Sor  = q_q[0];
  assign Sol  = q_q[WIDTH-1];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ushift_reg_burst.sv
// Directed self-checking bench for ushift_reg_burst (WIDTH=8, COUNT_W=4).
// Abort scenario runs only when USHIFT_REG_ABORT_EN is defined.
module tb_ushift_reg_burst;

  logic       Clck = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       Sir;
  logic       Sil;
  logic [7:0] Pin;
  logic       start;
  logic [3:0] count;
`ifdef USHIFT_REG_ABORT_EN
  logic       abort;
`endif
  logic [7:0] Q;
  logic       Sor;
  logic       Sol;
  logic       busy;
  logic       done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [2:0] M_HOLD = 3'b000, M_SHR = 3'b001, M_SHL = 3'b010,
                         M_LOAD = 3'b011, M_ROTR = 3'b100, M_ROTL = 3'b101,
                         M_ASHR = 3'b110, M_CLR = 3'b111;

  ushift_reg_burst #(.WIDTH(8), .COUNT_W(4)) dut (
    .Clck  (Clck),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .Sir   (Sir),
    .Sil   (Sil),
    .Pin   (Pin),
    .start (start),
    .count (count),
`ifdef USHIFT_REG_ABORT_EN
    .abort (abort),
`endif
    .Q     (Q),
    .Sor   (Sor),
    .Sol   (Sol),
    .busy  (busy),
    .done  (done)
  );

  always #5 Clck = ~Clck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clck);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = M_LOAD; Pin = v;
    step();
    en = 1'b0; mode = M_HOLD;
  endtask

  task automatic single_op(input string tag, input logic [2:0] m, input logic e,
                           input logic [7:0] exp);
    load(8'hB4);
    en = e; mode = m;
    step();
    check(tag, Q, exp);
    en = 1'b0; mode = M_HOLD;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = M_HOLD; Sir = 1'b0; Sil = 1'b0;
    Pin = '0; start = 1'b0; count = '0;
`ifdef USHIFT_REG_ABORT_EN
    abort = 1'b0;
`endif
    step();
    check("reset_q", Q, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    reset = 1'b1;
    step();

    // Single operations from 8'hB4
    Sir = 1'b1; Sil = 1'b1;
    single_op("shr", M_SHR, 1'b1, 8'hDA);
    single_op("shl", M_SHL, 1'b1, 8'h69);
    single_op("rotr", M_ROTR, 1'b1, 8'h5A);
    single_op("rotl", M_ROTL, 1'b1, 8'h69);
    single_op("ashr", M_ASHR, 1'b1, 8'hDA);
    single_op("clear", M_CLR, 1'b1, 8'h00);
    single_op("en_low_hold", M_SHR, 1'b0, 8'hB4);
    check("sor", Sor, 1'b0);
    check("sol", Sol, 1'b1);
    Sir = 1'b0; Sil = 1'b0;

    // Burst rotl x3 from 8'h81; start held high throughout must not retrigger
    load(8'h81);
    start = 1'b1; mode = M_ROTL; count = 4'd3;
    step();
    check("brot_q1", Q, 8'h03);
    check("brot_busy1", busy, 1'b1);
    step();
    check("brot_q2", Q, 8'h06);
    check("brot_busy2", busy, 1'b1);
    step();
    check("brot_q3", Q, 8'h0C);
    check("brot_busy3", busy, 1'b0);
    check("brot_done", done, 1'b1);
    step();
    start = 1'b0;
    check("brot_done_off", done, 1'b0);
    check("brot_idle_busy", busy, 1'b0);
    check("brot_start_in_done_ignored", Q, 8'h0C);

    // Burst shr x8 with serial input 1,0,1,1,0,0,1,0; mode changes ignored
    load(8'h00);
    start = 1'b1; mode = M_SHR; count = 4'd8; Sir = 1'b1;
    step();
    start = 1'b0;
    mode = M_LOAD; Pin = 8'hFF; Sir = 1'b0; step();
    mode = M_CLR;               Sir = 1'b1; step();
    mode = M_ROTL;              Sir = 1'b1; step();
    mode = M_SHL;               Sir = 1'b0; step();
    check("bser_busy_mid", busy, 1'b1);
    mode = M_HOLD;              Sir = 1'b0; step();
    mode = M_ASHR;              Sir = 1'b1; step();
    mode = M_LOAD;              Sir = 1'b0; step();
    check("bser_q", Q, 8'h4D);
    check("bser_done", done, 1'b1);
    mode = M_HOLD; Sir = 1'b0;
    step();
    check("bser_done_off", done, 1'b0);

    // Burst of WIDTH rotates returns the original value
    load(8'hA7);
    start = 1'b1; mode = M_ROTR; count = 4'd8;
    step();
    start = 1'b0;
    repeat (7) step();
    check("brot8_q", Q, 8'hA7);
    check("brot8_done", done, 1'b1);
    step();

    // Degenerate: count=0 with shl
    load(8'h5C);
    start = 1'b1; mode = M_SHL; count = 4'd0; Sil = 1'b1;
    step();
    start = 1'b0; Sil = 1'b0;
    check("cnt0_q", Q, 8'h5C);
    check("cnt0_done", done, 1'b1);
    check("cnt0_busy", busy, 1'b0);
    step();
    check("cnt0_done_off", done, 1'b0);

    // Degenerate: load via start
    start = 1'b1; mode = M_LOAD; Pin = 8'h3C; count = 4'd5;
    step();
    start = 1'b0; mode = M_HOLD;
    check("sload_q", Q, 8'h3C);
    check("sload_done", done, 1'b1);
    check("sload_busy", busy, 1'b0);
    step();
    check("sload_done_off", done, 1'b0);

`ifdef USHIFT_REG_ABORT_EN
    // Abort: rotl x7 from 8'h01, aborted on the third operation edge
    load(8'h01);
    start = 1'b1; mode = M_ROTL; count = 4'd7;
    step();
    start = 1'b0;
    step();
    check("abort_q_pre", Q, 8'h04);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_q", Q, 8'h04);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (3) begin
      step();
      check("abort_no_done", done, 1'b0);
      check("abort_q_hold", Q, 8'h04);
    end
`endif

    // Asynchronous reset mid-burst
    load(8'h5A);
    start = 1'b1; mode = M_ROTR; count = 4'd9;
    step();
    start = 1'b0;
    step(); step();
    check("rst_pre_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_q", Q, 8'h00);
    check("rst_async_busy", busy, 1'b0);
    step();
    #2 reset = 1'b1;
    repeat (10) begin
      step();
      check("rst_no_done", done, 1'b0);
    end
    check("rst_q_after", Q, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
